// File: rtl/mem_periph_pkg.sv
// -----------------------------------------------------------------------------
// mem_periph_pkg
// Shared constants for the memory-mapped peripheral block:
//   - byte addresses of every peripheral register
//   - bit positions inside TCON
//   - reset values of all peripheral state
//   - word_addr(): strips the byte offset so decode ignores Address[1:0]
// -----------------------------------------------------------------------------
package mem_periph_pkg;

   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
   localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
   localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

   localparam int TCON_EN = 0;   // timer enable
   localparam int TCON_IE = 1;   // interrupt enable
   localparam int TCON_IS = 2;   // interrupt status (sticky)

   localparam logic [31:0] TH_RST      = 32'h0000_0000;
   localparam logic [31:0] TL_RST      = 32'h0000_0000;
   localparam logic [2:0]  TCON_RST    = 3'b000;
   localparam logic [7:0]  LED_RST     = 8'h00;
   localparam logic [11:0] DIGI_RST    = 12'h000;
   localparam logic [31:0] SYSTICK_RST = 32'h0000_0000;

   function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/periph_timer.sv
// -----------------------------------------------------------------------------
// periph_timer
// Reloading up-counter with sticky interrupt status.
//   clk, reset     : clock / asynchronous active-low reset
//   th_we, tl_we,
//   tcon_we        : bus write strobes (already qualified by decode)
//   wdata          : bus write data
//   th, tl         : reload value and running count
//   tcon           : {status, int enable, timer enable}
//   irqout         : interrupt request (status AND enable)
// -----------------------------------------------------------------------------
module periph_timer
   import mem_periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irqout
);

   logic        reload_s;
   logic        set_is_s;
   logic [31:0] tl_next_s;
   logic [2:0]  tcon_base_s;
   logic [2:0]  tcon_next_s;

   // Reload fires on the edge after the counter reaches all-ones.
   always_comb begin
      reload_s = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
      set_is_s = reload_s && tcon[TCON_IE];
   end

   // Next count: software write beats reload, reload beats increment.
   // Reload uses the registered TH, so a TH write on the same edge is not seen.
   always_comb begin
      tl_next_s = tl;
      if (tl_we) begin
         tl_next_s = wdata;
      end else if (reload_s) begin
         tl_next_s = th;
      end else if (tcon[TCON_EN]) begin
         tl_next_s = tl + 32'd1;
      end else begin
         tl_next_s = tl;
      end
   end

   // Next TCON: the write updates all bits, but a coinciding reload can only
   // force status to 1, so a clear racing a new interrupt never loses it.
   always_comb begin
      tcon_base_s = tcon;
      if (tcon_we) begin
         tcon_base_s = wdata[2:0];
      end else begin
         tcon_base_s = tcon;
      end
      tcon_next_s = tcon_base_s | {set_is_s, 2'b00};
   end

   // Timer state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th   <= TH_RST;
         tl   <= TL_RST;
         tcon <= TCON_RST;
      end else begin
         if (th_we) begin
            th <= wdata;
         end
         tl   <= tl_next_s;
         tcon <= tcon_next_s;
      end
   end

   assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/mem_periph.sv
// -----------------------------------------------------------------------------
// mem_periph
// MEM-stage peripheral block: address decode, LED / seven-segment registers,
// switch input, optional SYSTICK counter, and the periph_timer instance.
//   clk, reset           : clock / asynchronous active-low reset
//   MemRead, MemWrite    : MEM-stage strobes
//   Address, Write_data  : bus address / store data
//   Read_data            : combinational load data (0 on miss or no read)
//   switch               : board switches
//   led, digi            : LED and seven-segment registers
//   irqout               : timer interrupt request
// Build option: define MEM_PERIPH_SYSTICK_EN to include the free-running
// SYSTICK counter; without it, its address reads 0.
// -----------------------------------------------------------------------------
module mem_periph
   import mem_periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   input  logic [7:0]  switch,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout
);

   logic [29:0] waddr_s;
   logic        unused_byte_sel_s;
   logic        th_we_s;
   logic        tl_we_s;
   logic        tcon_we_s;
   logic        led_we_s;
   logic        digi_we_s;
   logic [31:0] th_s;
   logic [31:0] tl_s;
   logic [2:0]  tcon_s;

   assign waddr_s           = Address[31:2];
   assign unused_byte_sel_s = ^Address[1:0];

   // Write strobes; read-only and unmapped addresses produce none.
   always_comb begin
      th_we_s   = MemWrite && (waddr_s == word_addr(ADDR_TH));
      tl_we_s   = MemWrite && (waddr_s == word_addr(ADDR_TL));
      tcon_we_s = MemWrite && (waddr_s == word_addr(ADDR_TCON));
      led_we_s  = MemWrite && (waddr_s == word_addr(ADDR_LED));
      digi_we_s = MemWrite && (waddr_s == word_addr(ADDR_DIGI));
   end

   periph_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .th_we   (th_we_s),
      .tl_we   (tl_we_s),
      .tcon_we (tcon_we_s),
      .wdata   (Write_data),
      .th      (th_s),
      .tl      (tl_s),
      .tcon    (tcon_s),
      .irqout  (irqout)
   );

   // LED and seven-segment registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led  <= LED_RST;
         digi <= DIGI_RST;
      end else begin
         if (led_we_s) begin
            led <= Write_data[7:0];
         end
         if (digi_we_s) begin
            digi <= Write_data[11:0];
         end
      end
   end

`ifdef MEM_PERIPH_SYSTICK_EN
   logic [31:0] systick_r;

   // Free-running cycle counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         systick_r <= SYSTICK_RST;
      end else begin
         systick_r <= systick_r + 32'd1;
      end
   end
`endif

   // Load data mux; registers are zero-extended to 32 bits.
   always_comb begin
      Read_data = 32'h0000_0000;
      if (MemRead) begin
         case (waddr_s)
            word_addr(ADDR_TH):      Read_data = th_s;
            word_addr(ADDR_TL):      Read_data = tl_s;
            word_addr(ADDR_TCON):    Read_data = {29'd0, tcon_s};
            word_addr(ADDR_LED):     Read_data = {24'd0, led};
            word_addr(ADDR_SWITCH):  Read_data = {24'd0, switch};
            word_addr(ADDR_DIGI):    Read_data = {20'd0, digi};
`ifdef MEM_PERIPH_SYSTICK_EN
            word_addr(ADDR_SYSTICK): Read_data = systick_r;
`endif
            default:                 Read_data = 32'h0000_0000;
         endcase
      end else begin
         Read_data = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mem_periph.sv
// -----------------------------------------------------------------------------
// tb_mem_periph
// Directed self-checking bench for mem_periph. Each task drives one scenario
// and compares against hand-computed values. Bus writes launch at the falling
// edge and take effect at the next rising edge; reads are sampled 1 ns after
// driving the address, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_periph;

   localparam logic [31:0] A_TH      = 32'h4000_0000;
   localparam logic [31:0] A_TL      = 32'h4000_0004;
   localparam logic [31:0] A_TCON    = 32'h4000_0008;
   localparam logic [31:0] A_LED     = 32'h4000_000C;
   localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
   localparam logic [31:0] A_DIGI    = 32'h4000_0014;
   localparam logic [31:0] A_SYSTICK = 32'h4000_0018;
   localparam logic [31:0] A_UNMAP   = 32'h4000_0020;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic [7:0]  switch;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   int checks = 0;
   int errors = 0;

   mem_periph dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .switch     (switch),
      .led        (led),
      .digi       (digi),
      .irqout     (irqout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Address    = a;
      Write_data = d;
      MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      MemWrite   = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      Address = a;
      MemRead = 1'b1;
      #1;
      d       = Read_data;
      MemRead = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (led !== 8'h00 || digi !== 12'h000 || irqout !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: led=%h digi=%h irq=%b required 00 000 0", led, digi, irqout);
      end
      bus_read(A_TCON, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL reset_tcon: got %h required 00000000", v);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_timer_irq();
      logic [31:0] v;
      bus_write(A_TH, 32'hFFFF_FFF0);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h0000_0003);
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL irq_tl0: got %h required fffffffe", v);
      end
      @(posedge clk); #1;
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL irq_tl1: got %h required ffffffff", v);
      end
      @(posedge clk); #1;
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL irq_reload: got %h required fffffff0", v);
      end
      bus_read(A_TCON, v);
      checks++;
      if (v !== 32'h7 || irqout !== 1'b1) begin
         errors++;
         $display("FAIL irq_tcon: tcon=%h irq=%b required 00000007 1", v, irqout);
      end
      bus_write(A_TCON, 32'h0000_0000);
   endtask

   task automatic test_reload_noirq_freeze();
      logic [31:0] v;
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h0000_0001);
      repeat (2) @(posedge clk);
      #1;
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL noirq_reload: got %h required fffffff0", v);
      end
      bus_read(A_TCON, v);
      checks++;
      if (v !== 32'h1 || irqout !== 1'b0) begin
         errors++;
         $display("FAIL noirq_tcon: tcon=%h irq=%b required 00000001 0", v, irqout);
      end
      // Disabling still lets this edge count once, then the value holds.
      bus_write(A_TCON, 32'h0000_0000);
      repeat (3) @(posedge clk);
      #1;
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFF1) begin
         errors++;
         $display("FAIL freeze: got %h required fffffff1", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      // TCON write racing a reload that sets status.
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h0000_0003);
      @(posedge clk);
      bus_write(A_TCON, 32'h0000_0003);
      bus_read(A_TCON, v);
      checks++;
      if (v !== 32'h7 || irqout !== 1'b1) begin
         errors++;
         $display("FAIL race_tcon: tcon=%h irq=%b required 00000007 1", v, irqout);
      end
      bus_write(A_TCON, 32'h0000_0003);
      checks++;
      if (irqout !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: irq=%b required 0", irqout);
      end
      // TH write racing a reload: reload takes the old TH.
      bus_write(A_TCON, 32'h0000_0000);
      bus_write(A_TH, 32'h0000_0100);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h0000_0001);
      @(posedge clk);
      bus_write(A_TH, 32'h0000_0200);
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'h0000_0100) begin
         errors++;
         $display("FAIL race_th_tl: got %h required 00000100", v);
      end
      bus_read(A_TH, v);
      checks++;
      if (v !== 32'h0000_0200) begin
         errors++;
         $display("FAIL race_th: got %h required 00000200", v);
      end
      // TL write racing a reload: the write wins, counting resumes from it.
      bus_write(A_TCON, 32'h0000_0000);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h0000_0001);
      @(posedge clk);
      bus_write(A_TL, 32'h0000_0077);
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'h0000_0077) begin
         errors++;
         $display("FAIL race_tl: got %h required 00000077", v);
      end
      @(posedge clk); #1;
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'h0000_0078) begin
         errors++;
         $display("FAIL race_tl_next: got %h required 00000078", v);
      end
      bus_write(A_TCON, 32'h0000_0000);
   endtask

   task automatic test_io();
      logic [31:0] v;
      switch = 8'hA5;
      bus_read(A_SWITCH, v);
      checks++;
      if (v !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL switch_read: got %h required 000000a5", v);
      end
      Address = A_SWITCH;
      MemRead = 1'b0;
      #1;
      checks++;
      if (Read_data !== 32'h0) begin
         errors++;
         $display("FAIL no_read: got %h required 00000000", Read_data);
      end
      bus_write(A_LED, 32'h0000_003C);
      bus_write(A_DIGI, 32'h0000_0123);
      bus_write(A_UNMAP, 32'h0000_00FF);
      bus_write(A_SWITCH, 32'h0000_0000);
      checks++;
      if (digi !== 12'h123 || led !== 8'h3C) begin
         errors++;
         $display("FAIL led_digi: digi=%h led=%h required 123 3c", digi, led);
      end
      bus_read(A_UNMAP, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read: got %h required 00000000", v);
      end
      bus_read(A_SWITCH, v);
      checks++;
      if (v !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL switch_ro: got %h required 000000a5", v);
      end
      bus_read(A_LED | 32'h0000_0003, v);
      checks++;
      if (v !== 32'h0000_003C) begin
         errors++;
         $display("FAIL byte_offset: got %h required 0000003c", v);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      bus_write(A_TL, 32'h0000_0055);
      bus_write(A_TCON, 32'h0000_0007);
      checks++;
      if (irqout !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_irq: irq=%b required 1", irqout);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (irqout !== 1'b0 || led !== 8'h00 || digi !== 12'h000) begin
         errors++;
         $display("FAIL async_reset: irq=%b led=%h digi=%h required 0 00 000", irqout, led, digi);
      end
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL async_tl: got %h required 00000000", v);
      end
      bus_read(A_TCON, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL async_tcon: got %h required 00000000", v);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      bus_read(A_SYSTICK, v);
      checks++;
`ifdef MEM_PERIPH_SYSTICK_EN
      if (v !== 32'h1) begin
         errors++;
         $display("FAIL systick: got %h required 00000001", v);
      end
`else
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL systick: got %h required 00000000", v);
      end
`endif
      bus_read(A_TL, v);
      checks++;
      if (v !== 32'h0 || irqout !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: tl=%h irq=%b required 00000000 0", v, irqout);
      end
   endtask

   initial begin
      reset      = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Address    = 32'h0;
      Write_data = 32'h0;
      switch     = 8'h00;
      test_reset();
      test_timer_irq();
      test_reload_noirq_freeze();
      test_back_to_back();
      test_io();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
